// File: rtl/wait_merge_n_pkg.sv
// Shared types for the N-way wait-merge join: FSM state encoding.
package wait_merge_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] ST_FIRE      = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT_FREE = 2'd2;
    localparam logic [STATE_W-1:0] ST_RELEASE   = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = ST_IDLE,
        FIRE      = ST_FIRE,
        WAIT_FREE = ST_WAIT_FREE,
        RELEASE   = ST_RELEASE
    } state_e;

endpackage

// File: rtl/wm_tok_cnt.sv
// Per-channel token counter: saturates at DEPTH, drops excess tokens and
// records the drop in a sticky overflow flag.
module wm_tok_cnt
    import wait_merge_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic arrive,
    input  logic consume,
    output logic nonzero,
    output logic overflow
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        // A same-cycle arrival and consume cancel out, even when full.
        if (arrive && !consume) begin
            if (cnt_q == CW'(DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (consume && !arrive) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign nonzero  = (cnt_q != '0);
    assign overflow = ovf_q;

endmodule

// File: rtl/wait_merge_n.sv
// N-way join: fires one downstream drive once every enabled channel holds a
// token, waits for the downstream free, then frees the consumed channels.
module wait_merge_n
    import wait_merge_pkg::*;
#(
    parameter int N     = 4,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_drive,
    output logic [N-1:0] o_free,
    input  logic [N-1:0] i_en_mask,
    output logic         o_driveNext,
    input  logic         i_freeNext,
    output logic [N-1:0] o_overflow,
    output logic         o_spurious,
    output logic         o_busy
);

    state_e       state_q, state_d;
    logic [N-1:0] mask_q, mask_d;
    logic [N-1:0] used_q, used_d;
    logic [N-1:0] free_q, free_d;
    logic         drive_q, drive_d;
    logic         spur_q, spur_d;
    logic         busy_q, busy_d;

    logic [N-1:0] consume;
    logic [N-1:0] nonzero;
    logic         ready;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ch
            wm_tok_cnt #(
                .DEPTH (DEPTH),
                .CW    (CW)
            ) u_cnt (
                .clk      (clk),
                .rst      (rst),
                .arrive   (i_drive[gi]),
                .consume  (consume[gi]),
                .nonzero  (nonzero[gi]),
                .overflow (o_overflow[gi])
            );
        end
    endgenerate

    // An all-zero mask would make the AND trivially true; never fire on it.
    assign ready = (&(~mask_q | nonzero)) && (mask_q != '0);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        used_d  = used_q;
        free_d  = '0;
        drive_d = 1'b0;
        consume = '0;
        spur_d  = spur_q | (i_freeNext && (state_q != WAIT_FREE));

        case (state_q)
            IDLE: begin
                mask_d = i_en_mask;
                if (ready) begin
                    state_d = FIRE;
                    consume = mask_q;
                    used_d  = mask_q;
                    drive_d = 1'b1;
                end
            end
            FIRE: begin
                state_d = WAIT_FREE;
            end
            WAIT_FREE: begin
                if (i_freeNext) begin
                    state_d = RELEASE;
                    free_d  = used_q;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            used_q  <= '0;
            free_q  <= '0;
            drive_q <= 1'b0;
            spur_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            used_q  <= used_d;
            free_q  <= free_d;
            drive_q <= drive_d;
            spur_q  <= spur_d;
            busy_q  <= busy_d;
        end
    end

    assign o_driveNext = drive_q;
    assign o_free      = free_q;
    assign o_spurious  = spur_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_wait_merge_n.sv
// Scoreboard bench for wait_merge_n (N=4, DEPTH=2): directed stimulus pushes
// expected output events and status checks; a negedge monitor compares them.
module tb_wait_merge_n;

    localparam int N     = 4;
    localparam int DEPTH = 2;

    localparam int S_OVF  = 0;
    localparam int S_SPUR = 1;
    localparam int S_BUSY = 2;
    localparam int S_PEND = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] i_drive = '0;
    logic [N-1:0] o_free;
    logic [N-1:0] i_en_mask = '1;
    logic         o_driveNext;
    logic         i_freeNext = 1'b0;
    logic [N-1:0] o_overflow;
    logic         o_spurious;
    logic         o_busy;

    typedef struct {
        bit           is_free;
        int           cyc;
        logic [N-1:0] val;
    } ev_t;

    typedef struct {
        int sel;
        int cyc;
        int val;
    } st_t;

    ev_t evq[$];
    st_t stq[$];

    int cyc      = 0;
    int n_checks = 0;
    int n_fails  = 0;

    wait_merge_n #(
        .N     (N),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .o_free      (o_free),
        .i_en_mask   (i_en_mask),
        .o_driveNext (o_driveNext),
        .i_freeNext  (i_freeNext),
        .o_overflow  (o_overflow),
        .o_spurious  (o_spurious),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    task automatic ev_check(input bit is_free, input logic [N-1:0] val);
        ev_t e;
        n_checks++;
        $display("cycle %0d: %s 0x%0h", cyc, is_free ? "o_free" : "o_driveNext", val);
        if (evq.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_%s: got 0x%0h at cycle %0d, required no output",
                     is_free ? "free" : "drive", val, cyc);
        end else begin
            e = evq.pop_front();
            if (e.is_free != is_free || e.cyc != cyc || e.val != val) begin
                n_fails++;
                $display("FAIL event: got %s 0x%0h at cycle %0d, required %s 0x%0h at cycle %0d",
                         is_free ? "free" : "drive", val, cyc,
                         e.is_free ? "free" : "drive", e.val, e.cyc);
            end
        end
    endtask

    task automatic st_check(input st_t s);
        int act;
        string nm;
        case (s.sel)
            S_OVF:   begin act = int'(o_overflow); nm = "overflow"; end
            S_SPUR:  begin act = int'(o_spurious); nm = "spurious"; end
            S_BUSY:  begin act = int'(o_busy);     nm = "busy";     end
            default: begin act = evq.size();       nm = "pending";  end
        endcase
        n_checks++;
        if (s.cyc != cyc || act != s.val) begin
            n_fails++;
            $display("FAIL %s: got %0d at cycle %0d, required %0d at cycle %0d",
                     nm, act, cyc, s.val, s.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (o_driveNext) ev_check(1'b0, '0);
        if (o_free != '0) ev_check(1'b1, o_free);
        while (stq.size() != 0 && stq[0].cyc <= cyc) begin
            st_check(stq.pop_front());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [N-1:0] v);
        i_drive = v;
        tick(1);
        i_drive = '0;
    endtask

    task automatic fnx();
        i_freeNext = 1'b1;
        tick(1);
        i_freeNext = 1'b0;
    endtask

    task automatic exp_ev(input bit is_free, input int c, input logic [N-1:0] v);
        ev_t e;
        e.is_free = is_free;
        e.cyc     = c;
        e.val     = v;
        evq.push_back(e);
    endtask

    task automatic chk(input int sel, input int v);
        st_t s;
        s.sel = sel;
        s.cyc = cyc;
        s.val = v;
        stq.push_back(s);
    endtask

    // Called in the cycle o_driveNext is high: wait into WAIT_FREE, free, settle.
    task automatic release_join(input logic [N-1:0] used);
        tick(2);
        exp_ev(1'b1, cyc + 1, used);
        fnx();
        chk(S_BUSY, 1);
        tick(1);
        chk(S_BUSY, 0);
    endtask

    initial begin
        // Reset, with inputs toggling that must be ignored.
        tick(1);
        i_drive    = '1;
        i_freeNext = 1'b1;
        tick(2);
        chk(S_BUSY, 0);
        chk(S_OVF, 0);
        rst        = 1'b1;
        i_drive    = '0;
        i_freeNext = 1'b0;
        tick(2);
        chk(S_SPUR, 0);
        chk(S_OVF, 0);
        chk(S_BUSY, 0);

        // Basic join: staggered tokens, fire two cycles after the last.
        drv(4'h1); tick(1);
        drv(4'h2); tick(1);
        drv(4'h4); tick(1);
        chk(S_BUSY, 0);
        exp_ev(1'b0, cyc + 2, '0);
        drv(4'h8);
        tick(1);
        chk(S_BUSY, 1);
        release_join(4'hF);

        // Masking: ch1 token counted but not consumed while disabled.
        i_en_mask = 4'b0101;
        tick(1);
        exp_ev(1'b0, cyc + 2, '0);
        drv(4'b0111);
        tick(1);
        release_join(4'b0101);
        exp_ev(1'b0, cyc + 2, '0);
        i_en_mask = 4'b0010;
        tick(2);
        release_join(4'b0010);

        // All-zero mask never fires, then enabling consumes the held tokens.
        i_en_mask = 4'b0000;
        tick(1);
        drv(4'hF);
        tick(50);
        chk(S_BUSY, 0);
        exp_ev(1'b0, cyc + 2, '0);
        i_en_mask = 4'hF;
        tick(2);
        release_join(4'hF);

        // Buffering: two tokens per channel yield two separately freed joins.
        i_en_mask = 4'b0000;
        tick(1);
        drv(4'hF);
        drv(4'hF);
        tick(1);
        exp_ev(1'b0, cyc + 2, '0);
        i_en_mask = 4'hF;
        tick(2);
        release_join(4'hF);
        exp_ev(1'b0, cyc + 1, '0);
        tick(1);
        release_join(4'hF);
        tick(5);
        chk(S_BUSY, 0);
        chk(S_OVF, 0);

        // Overflow on ch1: third token dropped, only two joins follow.
        i_en_mask = 4'b0000;
        tick(1);
        drv(4'b0010);
        drv(4'b0010);
        chk(S_OVF, 0);
        drv(4'b0010);
        chk(S_OVF, 4'b0010);
        drv(4'b1101);
        drv(4'b1101);
        exp_ev(1'b0, cyc + 2, '0);
        i_en_mask = 4'hF;
        tick(2);
        release_join(4'hF);
        exp_ev(1'b0, cyc + 1, '0);
        tick(1);
        release_join(4'hF);
        drv(4'b1101);
        tick(10);
        chk(S_BUSY, 0);
        chk(S_OVF, 4'b0010);
        exp_ev(1'b0, cyc + 2, '0);
        drv(4'b0010);
        tick(1);
        release_join(4'hF);

        // Arrival on ch0 in its consume cycle leaves cnt0 at 1.
        exp_ev(1'b0, cyc + 2, '0);
        drv(4'hF);
        drv(4'h1);
        release_join(4'hF);

        // Spurious free in IDLE: flagged, no o_free.
        chk(S_SPUR, 0);
        fnx();
        chk(S_SPUR, 1);
        tick(3);

        // Join on held cnt0; a free during FIRE must not end the wait.
        exp_ev(1'b0, cyc + 2, '0);
        drv(4'b1110);
        tick(1);
        fnx();
        tick(3);
        chk(S_BUSY, 1);
        exp_ev(1'b1, cyc + 1, 4'hF);
        fnx();
        tick(1);
        chk(S_BUSY, 0);

        // Reset during WAIT_FREE discards the join and buffered tokens.
        exp_ev(1'b0, cyc + 2, '0);
        drv(4'hF);
        tick(1);
        drv(4'hF);
        chk(S_BUSY, 1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk(S_BUSY, 0);
        chk(S_OVF, 0);
        chk(S_SPUR, 0);
        tick(6);
        chk(S_BUSY, 0);
        fnx();
        chk(S_SPUR, 1);
        tick(3);
        chk(S_PEND, 0);
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
